// File: rtl/vga_rom_arbiter.sv
// rtl/vga_rom_arbiter.sv - single-port ROM arbiter: fixed-priority VGA fetch plus one aux requester
//
// Shares one single-port glyph/bitmap ROM between the VGA pixel-fetch path and
// one auxiliary requester. VGA always wins and is never stalled. A 2-bit
// {vga,aux} tag travels alongside each issued address so returning ROM data is
// steered to the right requester. VGA read latency is a constant ROM_LAT+2.
//
// Optional feature macro: ROM_ARB_STAT_EN (adds STAT_W, stat_clr, stat_conf and
// a saturating conflict counter; arbitration is identical either way).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   vga_req    in   VGA fetch request this cycle
//   vga_addr   in   VGA fetch address
//   vga_data   out  VGA read data (holds when vga_vld=0)
//   vga_vld    out  VGA data valid pulse
//   aux_req    in   aux request, held until aux_ack
//   aux_addr   in   aux read address
//   aux_ack    out  aux address issued to ROM (1-cycle pulse)
//   aux_data   out  aux read data (holds when aux_vld=0)
//   aux_vld    out  aux data valid pulse
//   rom_addr   out  registered ROM address
//   rom_data   in   ROM read data, ROM_LAT cycles after rom_addr
//   stat_clr   in   clear conflict counter (ROM_ARB_STAT_EN only)
//   stat_conf  out  saturating conflict count (ROM_ARB_STAT_EN only)

module vga_rom_arbiter #(
    parameter int AW      = 11,
    parameter int DW      = 8,
    parameter int ROM_LAT = 1
`ifdef ROM_ARB_STAT_EN
    ,
    parameter int STAT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vga_req,
    input  logic [AW-1:0]     vga_addr,
    output logic [DW-1:0]     vga_data,
    output logic              vga_vld,
    input  logic              aux_req,
    input  logic [AW-1:0]     aux_addr,
    output logic              aux_ack,
    output logic [DW-1:0]     aux_data,
    output logic              aux_vld,
    output logic [AW-1:0]     rom_addr,
    input  logic [DW-1:0]     rom_data
`ifdef ROM_ARB_STAT_EN
    ,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_conf
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   rom_addr_q, rom_addr_d;
    logic [1:0]      tag_d;
    // tag_q[0] lines up with rom_addr; tag_q[ROM_LAT] lines up with rom_data.
    logic [1:0]      tag_q [ROM_LAT+1];
    logic [DW-1:0]   vga_data_q, aux_data_q;
    logic            vga_vld_q, aux_vld_q;
    logic            aux_gnt;

    // Grant and aux handshake FSM. VGA preempts aux unconditionally; aux is
    // only granted from IDLE so a request still high during its ack cycle is
    // not granted a second time.
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        tag_d      = 2'b00;
        aux_gnt    = 1'b0;

        if (vga_req) begin
            rom_addr_d = vga_addr;
            tag_d      = 2'b10;
        end else if (aux_req && (state_q == S_IDLE)) begin
            aux_gnt    = 1'b1;
            rom_addr_d = aux_addr;
            tag_d      = 2'b01;
        end

        case (state_q)
            S_IDLE: if (aux_gnt) state_d = S_ACK;
            S_ACK:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rom_addr_q <= '0;
            for (int i = 0; i <= ROM_LAT; i++) tag_q[i] <= 2'b00;
            vga_data_q <= '0;
            aux_data_q <= '0;
            vga_vld_q  <= 1'b0;
            aux_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            tag_q[0]   <= tag_d;
            for (int i = 1; i <= ROM_LAT; i++) tag_q[i] <= tag_q[i-1];
            vga_vld_q  <= tag_q[ROM_LAT][1];
            aux_vld_q  <= tag_q[ROM_LAT][0];
            if (tag_q[ROM_LAT][1]) vga_data_q <= rom_data;
            if (tag_q[ROM_LAT][0]) aux_data_q <= rom_data;
        end
    end

    assign rom_addr = rom_addr_q;
    assign aux_ack  = (state_q == S_ACK);
    assign vga_data = vga_data_q;
    assign vga_vld  = vga_vld_q;
    assign aux_data = aux_data_q;
    assign aux_vld  = aux_vld_q;

`ifdef ROM_ARB_STAT_EN
    // Conflict: VGA and aux both asking while aux would otherwise be grantable.
    logic [STAT_W-1:0] stat_q, stat_d;
    logic              conflict;

    assign conflict = vga_req && aux_req && (state_q == S_IDLE);

    always_comb begin
        stat_d = stat_q;
        if (stat_clr) begin
            stat_d = '0;
        end else if (conflict && (stat_q != {STAT_W{1'b1}})) begin
            stat_d = stat_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stat_q <= '0;
        else        stat_q <= stat_d;
    end

    assign stat_conf = stat_q;
`endif

endmodule

// File: tb/tb_vga_rom_arbiter.sv
// tb/tb_vga_rom_arbiter.sv - self-checking bench for vga_rom_arbiter

module tb_vga_rom_arbiter;

    localparam int AW      = 11;
    localparam int DW      = 8;
    localparam int ROM_LAT = 1;
`ifdef ROM_ARB_STAT_EN
    localparam int STAT_W  = 4;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vga_req, aux_req;
    logic [AW-1:0] vga_addr, aux_addr, rom_addr;
    logic [DW-1:0] vga_data, aux_data, rom_data;
    logic          vga_vld, aux_vld, aux_ack;
`ifdef ROM_ARB_STAT_EN
    logic              stat_clr;
    logic [STAT_W-1:0] stat_conf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_rom_arbiter #(
        .AW(AW), .DW(DW), .ROM_LAT(ROM_LAT)
`ifdef ROM_ARB_STAT_EN
        , .STAT_W(STAT_W)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data), .vga_vld(vga_vld),
        .aux_req(aux_req), .aux_addr(aux_addr), .aux_ack(aux_ack),
        .aux_data(aux_data), .aux_vld(aux_vld),
        .rom_addr(rom_addr), .rom_data(rom_data)
`ifdef ROM_ARB_STAT_EN
        , .stat_clr(stat_clr), .stat_conf(stat_conf)
`endif
    );

    // ROM contents: an arbitrary but address-dependent byte.
    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        return a[7:0] ^ {a[10:8], 5'b10101};
    endfunction

    logic [DW-1:0] rom_pipe [ROM_LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_f(rom_addr);
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[ROM_LAT-1];

    // Reference model: expected responses keyed by the cycle they must appear in.
    int            cyc;
    int            last_aux_gnt;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_vd [int];
    logic [DW-1:0] exp_ad [int];
    logic [DW-1:0] last_vd, last_ad;
    int            exp_stat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_vd.delete();
        exp_ad.delete();
        last_aux_gnt = -1000;
        exp_addr     = '0;
        last_vd      = '0;
        last_ad      = '0;
        exp_stat     = 0;
    endtask

    // One cycle: check outputs of cycle cyc, drive its inputs, advance.
    task automatic tick(input logic vr, input logic [AW-1:0] va,
                        input logic ar, input logic [AW-1:0] aa, input logic sc);
        logic ev, ea, idle;
        ev = exp_vd.exists(cyc);
        ea = exp_ad.exists(cyc);
        if (ev) begin last_vd = exp_vd[cyc]; exp_vd.delete(cyc); end
        if (ea) begin last_ad = exp_ad[cyc]; exp_ad.delete(cyc); end
        chk("vga_vld",  32'(vga_vld),  32'(ev));
        chk("aux_vld",  32'(aux_vld),  32'(ea));
        chk("vga_data", 32'(vga_data), 32'(last_vd));
        chk("aux_data", 32'(aux_data), 32'(last_ad));
        chk("aux_ack",  32'(aux_ack),  32'(last_aux_gnt == cyc - 1));
        chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
`ifdef ROM_ARB_STAT_EN
        chk("stat_conf", 32'(stat_conf), 32'(exp_stat));
        stat_clr = sc;
`endif
        vga_req = vr; vga_addr = va; aux_req = ar; aux_addr = aa;

        idle = (last_aux_gnt != cyc - 1);
        if (sc)                                   exp_stat = 0;
        else if (vr && ar && idle && exp_stat < 15) exp_stat = exp_stat + 1;
        if (vr) begin
            exp_addr = va;
            exp_vd[cyc + ROM_LAT + 2] = rom_f(va);
        end else if (ar && idle) begin
            exp_addr     = aa;
            last_aux_gnt = cyc;
            exp_ad[cyc + ROM_LAT + 2] = rom_f(aa);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst_n = 1'b0;
        vga_req = 1'b0; aux_req = 1'b0; vga_addr = '0; aux_addr = '0;
`ifdef ROM_ARB_STAT_EN
        stat_clr = 1'b0;
`endif
        cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_vga_vld",  32'(vga_vld),  0);
        chk("rst_aux_ack",  32'(aux_ack),  0);
        chk("rst_aux_vld",  32'(aux_vld),  0);
        rst_n = 1'b1;

        // Idle after reset.
        repeat (10) tick(1'b0, AW'($urandom), 1'b0, AW'($urandom), 1'b0);

        // Streaming VGA with aux starved throughout.
        for (int i = 0; i < 640; i++) tick(1'b1, AW'(i), 1'b1, AW'($urandom), 1'b0);
        repeat (5) tick(1'b0, '0, 1'b0, '0, 1'b0);

        // Aux held four cycles: grants two cycles apart.
        repeat (4) tick(1'b0, AW'($urandom), 1'b1, 11'h155, 1'b0);
        repeat (5) tick(1'b0, '0, 1'b0, '0, 1'b0);

        // Alternating VGA with aux always requesting.
        for (int i = 0; i < 64; i++)
            tick(1'(i % 2 == 0), AW'($urandom), 1'b1, AW'($urandom), 1'b0);
        repeat (5) tick(1'b0, '0, 1'b0, '0, 1'b0);

        // Fully random traffic.
        for (int i = 0; i < 400; i++)
            tick(1'($urandom_range(0, 1)), AW'($urandom), 1'($urandom_range(0, 1)),
                 AW'($urandom), 1'($urandom_range(0, 7) == 0));
        repeat (5) tick(1'b0, '0, 1'b0, '0, 1'b0);

        // Reset with reads in flight: all pending responses are dropped.
        repeat (3) tick(1'b1, AW'($urandom), 1'b0, '0, 1'b0);
        rst_n = 1'b0;
        vga_req = 1'b0; aux_req = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_vga_vld",  32'(vga_vld),  0);
        chk("mid_rst_vga_data", 32'(vga_data), 0);
        chk("mid_rst_rom_addr", 32'(rom_addr), 0);
        rst_n = 1'b1;
        cyc++;
        model_reset();
        repeat (8) tick(1'b0, '0, 1'b0, '0, 1'b0);

`ifdef ROM_ARB_STAT_EN
        // Saturation then clear-wins-over-increment.
        repeat (20) tick(1'b1, AW'($urandom), 1'b1, AW'($urandom), 1'b0);
        chk("stat_sat", 32'(stat_conf), 15);
        tick(1'b1, AW'($urandom), 1'b1, AW'($urandom), 1'b1);
        chk("stat_clr", 32'(stat_conf), 0);
        repeat (4) tick(1'b0, '0, 1'b0, '0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
